// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
// Addresses are handled as 64-bit here; narrower users truncate on the way back.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam int INST_BYTES = 4;

    function automatic logic [63:0] align4(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Byte-serial instruction fetch: reads four bytes little-endian from the instruction
// memory, presents the assembled word to decode over valid/ready, handles branch and halt.
//
// state | meaning
// FETCH | reading byte lane byte_cnt at pc + byte_cnt
// HOLD  | instruction valid, waiting for decode to accept
// HALT  | pc at or beyond end of memory, idle until branch or reset
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int unsigned       MEM_BYTES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT   = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(INST_BYTES);
    localparam logic              RESET_HALT  = (RESET_PC >= MEM_LIMIT);
    localparam fetch_state_e      RESET_STATE = RESET_HALT ? HALT : FETCH;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // Only lanes 0..2 are stored; lane 3 goes straight from mem_rdata into instruction.
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       instruction_q, instruction_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target_aligned;

    assign pc_plus4       = pc_q + PC_STEP;
    assign target_aligned = ADDR_W'(align4(64'(branch_target)));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        instruction_d = instruction_q;
        inst_pc_d     = inst_pc_q;
        inst_valid_d  = inst_valid_q;

        case (state_q)
            FETCH: begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                    2'd0: shift_d[7:0]   = mem_rdata;
                    2'd1: shift_d[15:8]  = mem_rdata;
                    2'd2: shift_d[23:16] = mem_rdata;
                    default: begin
                        instruction_d = {mem_rdata, shift_q};
                        inst_pc_d     = pc_q;
                        inst_valid_d  = 1'b1;
                        byte_cnt_d    = 2'd0;
                        state_d       = HOLD;
                    end
                endcase
            end
            HOLD: begin
                if (inst_ready) begin
                    pc_d         = pc_plus4;
                    inst_valid_d = 1'b0;
                    byte_cnt_d   = 2'd0;
                    state_d      = (pc_plus4 >= MEM_LIMIT) ? HALT : FETCH;
                end
            end
            HALT: begin
                inst_valid_d = 1'b0;
                byte_cnt_d   = 2'd0;
            end
            default: begin
                state_d      = RESET_STATE;
                inst_valid_d = 1'b0;
                byte_cnt_d   = 2'd0;
            end
        endcase

        // A redirect overrides everything; a handshake in the same cycle has already
        // been honoured by decode, so dropping inst_valid here loses nothing.
        if (branch_valid) begin
            pc_d         = target_aligned;
            byte_cnt_d   = 2'd0;
            inst_valid_d = 1'b0;
            state_d      = (target_aligned >= MEM_LIMIT) ? HALT : FETCH;
        end
    end

    assign halted_d = (state_d == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RESET_STATE;
            pc_q          <= RESET_PC;
            byte_cnt_q    <= 2'd0;
            shift_q       <= '0;
            instruction_q <= '0;
            inst_pc_q     <= RESET_PC;
            inst_valid_q  <= 1'b0;
            halted_q      <= RESET_HALT;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            instruction_q <= instruction_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_addr    = pc_q + ADDR_W'(byte_cnt_q);
    assign inst_valid  = inst_valid_q;
    assign instruction = instruction_q;
    assign inst_pc     = inst_pc_q;
    assign halted      = halted_q;

endmodule
